// File: rtl/pwm_pkg.sv
// Shared constants and FSM state encoding for the PWM capture block.
package pwm_pkg;

    localparam int PWM_N_DEFAULT    = 16;
    localparam int PWM_FILT_LEN_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_cap_sync.sv
// Input conditioning for pwm_capture: 2-FF synchronizer, optional glitch filter
// (compiled in with PWM_CAPTURE_FILTER_EN), previous-level register and edge decode.
module pwm_cap_sync
    import pwm_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    if (FILT_LEN < 1 || FILT_LEN > PWM_FILT_LEN_MAX) begin : g_bad_filt_len
        $error("pwm_cap_sync: FILT_LEN out of range 1..15");
    end

    logic s1_q, s2_q, s3_q;
    logic lvl;

    // NOTE: sequential state is assigned with <= only, so every register in
    // the chain samples the value from before this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pwm_in;
            s2_q <= s1_q;
            s3_q <= lvl;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam logic [3:0] STAB_LAST = 4'(FILT_LEN - 1);

    logic       filt_q, filt_d;
    logic [3:0] stab_q, stab_d;

    // The filtered level follows s2 only after FILT_LEN consecutive cycles of disagreement.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        filt_d = filt_q;
        stab_d = '0;
        if (s2_q != filt_q) begin
            if (stab_q == STAB_LAST) begin
                filt_d = s2_q;
            end else begin
                stab_d = stab_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_q <= 1'b0;
            stab_q <= '0;
        end else begin
            filt_q <= filt_d;
            stab_q <= stab_d;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = s2_q;
`endif

    assign level = lvl;
    assign rise  = lvl & ~s3_q;
    assign fall  = ~lvl & s3_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input in clk cycles.
// Optional glitch filter selected by PWM_CAPTURE_FILTER_EN (see pwm_cap_sync).
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int N        = PWM_N_DEFAULT,
    parameter int FILT_LEN = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         pwm_in,
    output logic [N-1:0] period,
    output logic [N-1:0] high_time,
    output logic         valid,
    output logic         timeout,
    output logic         level
);

    localparam logic [N-1:0] CNT_MAX = '1;

    logic rise, fall;

    pwm_cap_sync #(
        .FILT_LEN (FILT_LEN)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    pwm_state_e   state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] hi_q, hi_d;
    logic [N-1:0] period_q, period_d;
    logic [N-1:0] high_q, high_d;
    logic         valid_q, valid_d;
    logic         timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        if (rise) begin
            cnt_d = N'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + N'(1);
        end

        // Disable overrides everything; rise outranks saturation in LOW.
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rise) state_d = ST_HIGH;
                end
                ST_HIGH: begin
                    if (fall) begin
                        state_d = ST_LOW;
                        hi_d    = cnt_q;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        state_d   = ST_HIGH;
                        period_d  = cnt_q;
                        high_d    = hi_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture (N=8 so saturation is reachable quickly).
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int N        = 8;
    localparam int FILT_LEN = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         pwm_in;
    logic [N-1:0] period;
    logic [N-1:0] high_time;
    logic         valid;
    logic         timeout;
    logic         level;

    int tests_run    = 0;
    int tests_failed = 0;

    int cyc       = 0;
    int vcount    = 0;
    int vlast_cyc = 0;
    int vgap      = 0;
    int base;

    pwm_capture #(
        .N        (N),
        .FILT_LEN (FILT_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pwm_in    (pwm_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout),
        .level     (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Valid-strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid) begin
            vgap      = cyc - vlast_cyc;
            vlast_cyc = cyc;
            vcount    = vcount + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One pwm_in sample per clock; inputs change 1 time unit after the rising edge.
    task automatic drive(input bit v);
        pwm_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic wave(input int p, input int h, input int m);
        for (int k = 0; k < m; k++)
            for (int i = 0; i < p; i++)
                drive(i < h);
    endtask

    task automatic lows(input int n);
        for (int i = 0; i < n; i++) drive(1'b0);
    endtask

    // P=40, H=10 with a 2-cycle low glitch at cycles 4..5 of the high phase.
    task automatic glitch_wave(input int m);
        for (int k = 0; k < m; k++)
            for (int i = 0; i < 40; i++)
                drive((i < 10) && (i != 4) && (i != 5));
    endtask

    task automatic do_reset;
        rst_n  = 1'b0;
        en     = 1'b1;
        pwm_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst period", 32'(period), 0);
        check("rst high_time", 32'(high_time), 0);
        check("rst valid", 32'(valid), 0);
        check("rst timeout", 32'(timeout), 0);
        check("rst level", 32'(level), 0);

        // P=10, H=3: first rise only arms; valid 3 edges after the second rise is driven
        base = vcount;
        wave(10, 3, 1);
        check("p10 no valid after 1st rise", 32'(vcount - base), 0);
        drive(1'b1);
        drive(1'b1);
        check("p10 valid not yet", 32'(valid), 0);
        drive(1'b1);
        check("p10 valid latency", 32'(valid), 1);
        check("p10 level high", 32'(level), 1);
        check("p10 first period", 32'(period), 10);
        check("p10 first high", 32'(high_time), 3);
        lows(7);
        wave(10, 3, 3);
        lows(5);
        check("p10 valid count", 32'(vcount - base), 4);
        check("p10 valid spacing", 32'(vgap), 10);
        check("p10 period", 32'(period), 10);
        check("p10 high", 32'(high_time), 3);
        check("p10 timeout", 32'(timeout), 0);

        // Held high after one rise: saturation at 2^N-1 -> timeout, IDLE
        do_reset();
        base = vcount;
        for (int i = 0; i < 257; i++) drive(1'b1);
        check("to not yet", 32'(timeout), 0);
        drive(1'b1);
        check("to asserted", 32'(timeout), 1);
        check("to level", 32'(level), 1);
        check("to state idle", 32'(dut.state_q), 32'(ST_IDLE));
        check("to no valid", 32'(vcount - base), 0);
        wave(20, 5, 4);
        lows(5);
        check("to recover count", 32'(vcount - base), 2);
        check("to recover period", 32'(period), 20);
        check("to recover high", 32'(high_time), 5);
        check("to cleared", 32'(timeout), 0);

        // Minimum period P=2, H=1
        do_reset();
        base = vcount;
        wave(2, 1, 6);
        lows(4);
        check("p2 count", 32'(vcount - base), 5);
        check("p2 spacing", 32'(vgap), 2);
        check("p2 period", 32'(period), 2);
        check("p2 high", 32'(high_time), 1);

        // Reset pulse during the LOW phase
        do_reset();
        wave(10, 3, 3);
        drive(1'b1); drive(1'b1); drive(1'b1);
        lows(3);
        check("mid pre period", 32'(period), 10);
        rst_n = 1'b0;
        drive(1'b0);
        rst_n = 1'b1;
        check("mid rst period", 32'(period), 0);
        check("mid rst high", 32'(high_time), 0);
        check("mid rst valid", 32'(valid), 0);
        check("mid rst timeout", 32'(timeout), 0);
        check("mid rst level", 32'(level), 0);
        base = vcount;
        wave(10, 3, 1);
        check("mid arm only", 32'(vcount - base), 0);
        wave(10, 3, 2);
        lows(5);
        check("mid count", 32'(vcount - base), 2);
        check("mid period", 32'(period), 10);
        check("mid high", 32'(high_time), 3);

        // Short low glitch inside the high phase
        do_reset();
        base = vcount;
        glitch_wave(4);
        lows(10);
`ifdef PWM_CAPTURE_FILTER_EN
        check("glitch count", 32'(vcount - base), 3);
        check("glitch period", 32'(period), 40);
        check("glitch high", 32'(high_time), 10);
`else
        check("glitch count", 32'(vcount - base), 7);
        check("glitch period", 32'(period), 6);
        check("glitch high", 32'(high_time), 4);
`endif

        // en low for 3 cycles swallowing a rising edge
        do_reset();
        wave(10, 3, 3);
        base = vcount;
        en = 1'b0;
        drive(1'b1); drive(1'b1); drive(1'b1);
        en = 1'b1;
        lows(7);
        check("en no valid", 32'(vcount - base), 0);
        wave(10, 3, 1);
        check("en rearm only", 32'(vcount - base), 0);
        wave(10, 3, 1);
        lows(5);
        check("en resume count", 32'(vcount - base), 1);
        check("en resume period", 32'(period), 10);
        check("en resume high", 32'(high_time), 3);
        check("en timeout", 32'(timeout), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
